// File: rtl/zap_branch_predict_updater_pkg.sv
// Shared types and helpers for the branch-prediction counter updater:
// FSM encodings, index-width function and saturating counter arithmetic.
package zap_branch_predict_updater_pkg;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counters up to 8 bits wide; callers truncate to their own width.
    function automatic logic [7:0] sat_next(input logic [7:0] base,
                                            input logic       taken,
                                            input logic [7:0] max_val);
        logic [7:0] r;
        if (taken) r = (base >= max_val) ? max_val : base + 8'd1;
        else       r = (base == 8'd0)    ? 8'd0    : base - 8'd1;
        return r;
    endfunction

endpackage

// File: rtl/zap_branch_predict_updater_sat.sv
// Combinational next value of a saturating branch counter.
module zap_sat_counter_next
    import zap_branch_predict_updater_pkg::*;
#(
    parameter int ENTRY_SIZE = 2
) (
    input  logic [ENTRY_SIZE-1:0] base,
    input  logic                  taken,
    output logic [ENTRY_SIZE-1:0] next
);
    localparam logic [7:0] MAX_VAL = 8'((1 << ENTRY_SIZE) - 1);

    assign next = ENTRY_SIZE'(sat_next(8'(base), taken, MAX_VAL));

endmodule

// File: rtl/zap_branch_predict_updater.sv
// Write-side controller for the branch counter RAM: clears the table after
// reset, then does a pipelined read-modify-write per resolved branch.
module zap_branch_predict_updater
    import zap_branch_predict_updater_pkg::*;
#(
    parameter int NUMBER_OF_ENTRIES = 64,
    parameter int ENTRY_SIZE        = 2,
    parameter int IDX_LO            = 1,
    localparam int AW               = idx_bits(NUMBER_OF_ENTRIES)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_upd_valid,
    input  logic [31:0]           i_upd_pc,
    input  logic                  i_upd_taken,
    output logic                  o_upd_ready,
    output logic                  o_init_done,
    output logic [AW-1:0]         o_ram_rd_addr,
    input  logic [ENTRY_SIZE-1:0] i_ram_rd_data,
    output logic                  o_ram_wr_en,
    output logic [AW-1:0]         o_ram_wr_addr,
    output logic [ENTRY_SIZE-1:0] o_ram_wr_data
);
    logic [0:0]            state;
    logic [AW:0]           sweep_cnt;
    logic                  s1_valid;
    logic                  s1_taken;
    logic [AW-1:0]         s1_idx;
    logic                  w2_valid;
    logic [AW-1:0]         w2_addr;
    logic [ENTRY_SIZE-1:0] w2_data;
    logic [ENTRY_SIZE-1:0] base;
    logic [ENTRY_SIZE-1:0] next;
    logic [AW-1:0]         upd_idx;
    logic                  accept;
    logic                  pc_unused;

    assign upd_idx   = i_upd_pc[IDX_LO +: AW];
    assign pc_unused = ^i_upd_pc;

    assign o_upd_ready   = (state == ST_RUN);
    assign o_init_done   = (state == ST_RUN);
    assign accept        = i_upd_valid & o_upd_ready;
    assign o_ram_rd_addr = accept ? upd_idx : '0;

    // The RAM read for an S1 entry misses the two writes issued just before
    // it; the newest matching write (W1 = current outputs) takes priority.
    always_comb begin
        base = i_ram_rd_data;
        if (o_ram_wr_en && o_ram_wr_addr == s1_idx)
            base = o_ram_wr_data;
        else if (w2_valid && w2_addr == s1_idx)
            base = w2_data;
    end

    zap_sat_counter_next #(.ENTRY_SIZE(ENTRY_SIZE)) u_sat (
        .base  (base),
        .taken (s1_taken),
        .next  (next)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= ST_INIT;
            sweep_cnt     <= '0;
            s1_valid      <= 1'b0;
            s1_taken      <= 1'b0;
            s1_idx        <= '0;
            w2_valid      <= 1'b0;
            w2_addr       <= '0;
            w2_data       <= '0;
            o_ram_wr_en   <= 1'b0;
            o_ram_wr_addr <= '0;
            o_ram_wr_data <= '0;
        end else begin
            w2_valid <= o_ram_wr_en;
            w2_addr  <= o_ram_wr_addr;
            w2_data  <= o_ram_wr_data;
            s1_valid <= accept;
            s1_idx   <= upd_idx;
            s1_taken <= i_upd_taken;
            if (state == ST_INIT) begin
                // One idle cycle after the last clear write before opening up.
                if (sweep_cnt == (AW+1)'(NUMBER_OF_ENTRIES)) begin
                    state       <= ST_RUN;
                    o_ram_wr_en <= 1'b0;
                end else begin
                    o_ram_wr_en   <= 1'b1;
                    o_ram_wr_addr <= sweep_cnt[AW-1:0];
                    o_ram_wr_data <= '0;
                    sweep_cnt     <= sweep_cnt + 1'b1;
                end
            end else begin
                o_ram_wr_en   <= s1_valid;
                o_ram_wr_addr <= s1_idx;
                o_ram_wr_data <= next;
            end
        end
    end

endmodule

// File: tb/tb_zap_branch_predict_updater.sv
// Directed bench for zap_branch_predict_updater with a behavioural counter RAM.
module tb_zap_branch_predict_updater;

    logic        clk;
    logic        rst_n;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_ready;
    logic        init_done;
    logic [5:0]  rd_addr;
    logic [1:0]  rd_data;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [1:0]  wr_data;

    int n_chk  = 0;
    int n_fail = 0;
    int bad_commits = 0;
    logic watch_24 = 1'b0;

    logic [1:0] mem [64];

    zap_branch_predict_updater #(
        .NUMBER_OF_ENTRIES(64), .ENTRY_SIZE(2), .IDX_LO(1)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_upd_valid   (upd_valid),
        .i_upd_pc      (upd_pc),
        .i_upd_taken   (upd_taken),
        .o_upd_ready   (upd_ready),
        .o_init_done   (init_done),
        .o_ram_rd_addr (rd_addr),
        .i_ram_rd_data (rd_data),
        .o_ram_wr_en   (wr_en),
        .o_ram_wr_addr (wr_addr),
        .o_ram_wr_data (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read returns the pre-write value when read and write collide.
    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
        if (watch_24 && wr_en && wr_addr == 6'd24 && wr_data != 2'd0)
            bad_commits = bad_commits + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expects reset released at a negedge; leaves the bench at the negedge of cycle N+1.
    task automatic run_sweep();
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            check($sformatf("sweep_%0d", k),
                  32'({init_done, upd_ready, wr_en, wr_addr, wr_data}),
                  32'({1'b0, 1'b0, 1'b1, 6'(k-1), 2'd0}));
        end
        @(negedge clk);
        check("init_done", 32'({init_done, upd_ready, wr_en}), 32'({1'b1, 1'b1, 1'b0}));
    endtask

    typedef struct {
        logic        pre;
        logic [1:0]  pre_val;
        logic [31:0] pc;
        logic        taken;
        logic [5:0]  addr;
        logic [1:0]  data;
    } vec_t;

    vec_t vecs[11];
    logic [31:0] seq_pc [3];
    logic [5:0]  seq_addr [3];
    logic [1:0]  seq_data [3];
    logic [1:0]  b2b_data [4];

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 32'h104, 1'b1, 6'd2,  2'd1};
        vecs[1]  = '{1'b0, 2'd0, 32'h104, 1'b1, 6'd2,  2'd2};
        vecs[2]  = '{1'b0, 2'd0, 32'h104, 1'b0, 6'd2,  2'd1};
        vecs[3]  = '{1'b0, 2'd0, 32'h000, 1'b0, 6'd0,  2'd0};
        vecs[4]  = '{1'b0, 2'd0, 32'h07E, 1'b1, 6'd63, 2'd1};
        vecs[5]  = '{1'b0, 2'd0, 32'h080, 1'b1, 6'd0,  2'd1};
        vecs[6]  = '{1'b0, 2'd0, 32'h105, 1'b1, 6'd2,  2'd2};
        vecs[7]  = '{1'b1, 2'd3, 32'h00A, 1'b1, 6'd5,  2'd3};
        vecs[8]  = '{1'b1, 2'd0, 32'h00C, 1'b0, 6'd6,  2'd0};
        vecs[9]  = '{1'b1, 2'd2, 32'h00E, 1'b1, 6'd7,  2'd3};
        vecs[10] = '{1'b0, 2'd0, 32'h00E, 1'b0, 6'd7,  2'd2};
        seq_pc   = '{32'h28, 32'h2A, 32'h28};
        seq_addr = '{6'd20, 6'd21, 6'd20};
        seq_data = '{2'd1, 2'd1, 2'd2};
        b2b_data = '{2'd1, 2'd2, 2'd3, 2'd3};
        for (int i = 0; i < 64; i++) mem[i] = 2'd3;

        rst_n = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state",
              32'({upd_ready, init_done, wr_en, wr_addr, wr_data, rd_addr}), 32'd0);

        // Reset in the middle of the sweep, right after entry 20 is presented.
        rst_n = 1'b1;
        for (int k = 1; k <= 21; k++) @(negedge clk);
        check("sweep_at_20", 32'({wr_en, wr_addr}), 32'({1'b1, 6'd20}));
        rst_n = 1'b0;
        #1;
        check("midsweep_reset", 32'({wr_en, wr_addr, upd_ready}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_sweep();

        foreach (vecs[i]) begin
            if (vecs[i].pre) mem[vecs[i].addr] = vecs[i].pre_val;
            upd_valid = 1'b1; upd_pc = vecs[i].pc; upd_taken = vecs[i].taken;
            #1;
            check($sformatf("rd_addr_v%0d", i), 32'(rd_addr), 32'(vecs[i].addr));
            @(negedge clk);
            upd_valid = 1'b0;
            check($sformatf("no_write_v%0d", i), 32'(wr_en), 32'd0);
            @(negedge clk);
            check($sformatf("write_v%0d", i), 32'({wr_en, wr_addr, wr_data}),
                  32'({1'b1, vecs[i].addr, vecs[i].data}));
            @(negedge clk);
        end

        // Four back-to-back taken events on index 8: W1 forwarding each cycle.
        upd_pc = 32'h10; upd_taken = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i >= 2 && i <= 5)
                check($sformatf("b2b_%0d", i-2), 32'({wr_en, wr_addr, wr_data}),
                      32'({1'b1, 6'd8, b2b_data[i-2]}));
            upd_valid = (i < 4);
            @(negedge clk);
        end

        // Index 20, 21, 20: the third event forwards from W2.
        for (int i = 0; i < 6; i++) begin
            if (i >= 2 && i <= 4)
                check($sformatf("w2_seq_%0d", i-2), 32'({wr_en, wr_addr, wr_data}),
                      32'({1'b1, seq_addr[i-2], seq_data[i-2]}));
            upd_valid = (i < 3);
            if (i < 3) upd_pc = seq_pc[i];
            @(negedge clk);
        end

        // Two updates to index 24 in flight, then reset before either commits.
        upd_valid = 1'b1; upd_pc = 32'h30; upd_taken = 1'b1;
        watch_24 = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0; upd_valid = 1'b0;
        #1;
        check("inflight_reset", 32'({wr_en, upd_ready}), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("reset_hold", 32'({wr_en, wr_addr, wr_data}), 32'd0);
        end
        rst_n = 1'b1;
        run_sweep();
        check("aborted_writes", 32'(bad_commits), 32'd0);

        // First update after re-init sees the cleared entry.
        upd_valid = 1'b1; upd_pc = 32'h30; upd_taken = 1'b1;
        @(negedge clk);
        upd_valid = 1'b0;
        @(negedge clk);
        check("post_reinit", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 6'd24, 2'd1}));
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
